// File: rtl/ascon_sigma_seq.sv
// Sequencer applying Sigma0..Sigma4 to a 320-bit Ascon state over the shared 32-bit sigma datapath.
// Optional abort input is enabled by defining ASCON_SIGMA_SEQ_ABORT_EN.

module ascon_sigma_seq #(
    parameter int LOGIC_GATING = 1,
    parameter int STARVE_MAX   = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    output logic         req_ready_o,
    input  logic [319:0] state_i,
    output logic         res_valid_o,
    input  logic         res_ready_i,
    output logic [319:0] state_o,
    input  logic         core_en_i,
    output logic         core_stall_o,
    output logic         seq_grant_o,
    output logic         ascon_en_o,
    output logic [3:0]   ascon_op_o,
    output logic [31:0]  op_a_o,
    output logic [31:0]  op_b_o,
    input  logic [31:0]  ascon_result_i
`ifdef ASCON_SIGMA_SEQ_ABORT_EN
    ,
    input  logic         abort_i
`endif
);

    // ascon_op_o encoding: 2n selects ASCSIGnL, 2n+1 selects ASCSIGnH, so the op equals the step index.
    localparam int SW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t          fsm;
    logic [3:0]    step;
    logic [SW-1:0] starve_cnt;
    logic [319:0]  src;
    logic [63:0]   lane;
    logic          abort;
    logic          running;
    logic          starve_hit;
    logic          grant;

`ifdef ASCON_SIGMA_SEQ_ABORT_EN
    assign abort = abort_i;
`else
    assign abort = 1'b0;
`endif

    assign running     = (fsm == RUN);
    assign req_ready_o = (fsm == IDLE);

    // Operands come from a private copy of the input, since state_o is overwritten half a lane at a time.
    assign lane = src[{step[3:1], 6'b0} +: 64];

    assign starve_hit   = (STARVE_MAX != 0) && (starve_cnt == STARVE_LIM);
    assign grant        = running && !abort && (!core_en_i || starve_hit);
    assign seq_grant_o  = grant;
    assign ascon_en_o   = grant;
    assign core_stall_o = grant && core_en_i;
    assign ascon_op_o   = running ? step : 4'd0;
    assign op_a_o       = (LOGIC_GATING == 0 || grant) ? lane[31:0]  : 32'd0;
    assign op_b_o       = (LOGIC_GATING == 0 || grant) ? lane[63:32] : 32'd0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm         <= IDLE;
            step        <= 4'd0;
            starve_cnt  <= '0;
            src         <= '0;
            state_o     <= '0;
            res_valid_o <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (start_i) begin
                        src        <= state_i;
                        step       <= 4'd0;
                        starve_cnt <= '0;
                        fsm        <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_o    <= '0;
                        starve_cnt <= '0;
                        fsm        <= IDLE;
                    end else if (grant) begin
                        // {step,5'b0} is 64*lane + 32*half, the word this step produces.
                        state_o[{step, 5'b0} +: 32] <= ascon_result_i;
                        starve_cnt <= '0;
                        if (step == 4'd9) begin
                            res_valid_o <= 1'b1;
                            fsm         <= DONE;
                        end else begin
                            step <= step + 4'd1;
                        end
                    end else if (starve_cnt != STARVE_LIM) begin
                        starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                DONE: begin
                    if (abort) begin
                        state_o     <= '0;
                        res_valid_o <= 1'b0;
                        fsm         <= IDLE;
                    end else if (res_ready_i) begin
                        res_valid_o <= 1'b0;
                        fsm         <= IDLE;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/ascon_sigma_seq.md
Name: ascon_sigma_seq

Overview:
- Sequencer that applies the full Ascon linear diffusion layer (Sigma0..Sigma4) to a 320-bit state.
- Drives the shared 32-bit Ascon sigma datapath through ten half-lane operations (L then H per lane) and collects the results into a 320-bit output register.
- Shares the datapath with the Ibex core's own ASCSIG* instructions. The core has priority; a starvation limit guarantees forward progress.

Parameters:
- LOGIC_GATING, 1: when 1, op_a_o/op_b_o are forced to 0 in any cycle ascon_en_o=0.
- STARVE_MAX, 8: consecutive core-held cycles after which the sequencer forces one grant; 0 = never force.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- start_i  in  1  request valid
- req_ready_o  out  1  request accepted when start_i && req_ready_o
- state_i  in  320  input state; lane i = state_i[64i+63:64i]
- res_valid_o  out  1  result valid
- res_ready_i  in  1  result consumed when res_valid_o && res_ready_i
- state_o  out  320  diffused state, same lane layout
- core_en_i  in  1  core wants the sigma datapath this cycle
- core_stall_o  out  1  core must stall this cycle (forced grant)
- seq_grant_o  out  1  external mux selects sequencer operands/op
- ascon_en_o  out  1  datapath enable from sequencer
- ascon_op_o  out  ascon_op_t  ASCSIGnL/ASCSIGnH select
- op_a_o  out  32  low word of the current lane
- op_b_o  out  32  high word of the current lane
- ascon_result_i  in  32  combinational datapath result

Behaviour:
- Clocking/reset: one clock domain, clk_i; rst_ni is asynchronous, active-low.
- Reset values: FSM=IDLE, step counter=0, starve counter=0, state_o=0, res_valid_o=0, req_ready_o=1 (combinational from IDLE), all datapath outputs=0, core_stall_o=0.
- States:
  - IDLE: req_ready_o=1. On accept, latch state_i, step k=0, go to RUN.
  - RUN: step k (0..9) targets lane n=k>>1. Op is ASCSIGnL for even k, ASCSIGnH for odd k. op_a_o=lane[31:0], op_b_o=lane[63:32].
  - DONE: res_valid_o=1, state_o held stable. On res_ready_i, go to IDLE. Next start is accepted only from IDLE, so there is at least 1 bubble cycle.
- Grant in RUN:
  - grant = !core_en_i || (STARVE_MAX!=0 && starve_cnt==STARVE_MAX).
  - core_stall_o = core_en_i && grant.
  - seq_grant_o = ascon_en_o = grant.
- Issue: on a grant cycle, ascon_result_i is written to state_o[64n+32*(k&1) +: 32] at the clock edge. k increments; k==9 transitions to DONE.
- Stall: on a no-grant cycle, k holds, starve_cnt increments (saturating). Any grant clears starve_cnt.
- Latency: exactly 10 grant cycles from accept to res_valid_o; minimum 10 cycles with core_en_i=0.
- Outside RUN: seq_grant_o=ascon_en_o=core_stall_o=0, and the core owns the datapath freely.
- Simultaneous events: core_en_i high in the same cycle as accept has no effect (the sequencer is not yet in RUN). core_en_i is ignored in IDLE and DONE.
- Partial-result visibility: state_o words not yet written during RUN are don't-care. Only DONE guarantees all 10 words.
- Reset mid-operation: immediate return to IDLE. Partial results are discarded and state_o clears to 0.
- No arithmetic beyond indexing: k is 4-bit, starve_cnt is $clog2(STARVE_MAX+1)-bit saturating.

Optional Feature:
- Macro: ASCON_SIGMA_SEQ_ABORT_EN.
- Defined:
  - Adds input abort_i. abort_i high in RUN or DONE returns to IDLE on the next edge.
  - res_valid_o drops, state_o is cleared to 0, and no grant is issued in the abort cycle.
  - abort_i in IDLE is ignored. If start_i and abort_i are both high in IDLE, the start is accepted.
- Undefined: no abort_i port; an accepted operation always runs to DONE.

Test Plan:
- Zero state, core_en_i=0, res_ready_i=1 → res_valid_o exactly 10 cycles after accept; state_o=0. Ops issued in order SIG0L,SIG0H,...,SIG4H.
- Lane0=64'h1, other lanes 0 → state_o lane0=64'h0000_2010_0000_0001, other lanes 0.
- Lane1=64'h1, other lanes 0 → state_o lane1=64'h0000_0000_0200_0009, other lanes 0.
- core_en_i held high from step 3, STARVE_MAX=8 → 8 stall cycles, then one forced grant with core_stall_o=1, repeating. Completion after 10 grants; result matches the unstalled run.
- Reset asserted at step 5, released, new start with lane0=1 → IDLE with state_o=0 on reset; the new run produces the lane0 vector above.
- res_ready_i=0 for 4 cycles in DONE → res_valid_o and state_o stable, req_ready_o=0, then return to IDLE on handshake.
